// File: rtl/stack_evaluator.sv
// stack_evaluator: precedence infix evaluator over an operand stack and an
// operator stack; one reduction per cycle, result or error held until clear.
module stack_evaluator #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             strobe,
    input  logic [1:0]       kind,
    input  logic [WIDTH-1:0] value,
    input  logic             clear,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] answer,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] E_SYN = 2'd1;
    localparam logic [1:0] E_OVF = 2'd2;
    localparam logic [1:0] E_DIV = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_REDUCE, S_FINAL, S_DONE, S_ERR
    } state_t;

    state_t state;

    // operator encoding: 0 +, 1 -, 2 *, 3 /; bit 1 set means high precedence
    logic [WIDTH-1:0] ostk [DEPTH];
    logic [1:0]       pstk [DEPTH];
    logic [CW-1:0]    ocnt;
    logic [CW-1:0]    pcnt;
    logic             expect_operand;
    logic [1:0]       pend;

    logic [IW-1:0]           b_i;
    logic [IW-1:0]           a_i;
    logic [IW-1:0]           p_i;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] res;
    logic [1:0]              top_op;
    logic [1:0]              new_op;
    logic                    code_ok;
    logic                    div_zero;
    logic                    few;
    logic                    ofull;
    logic                    pfull;
    logic                    stop;
    logic                    can_push;
    logic                    tok_opnd;
    logic                    tok_optr;
    logic                    tok_eq;
    logic                    tok_bad;

    // stack tops, token classification and the arithmetic of one reduction
    always_comb begin
        b_i      = IW'(ocnt - CW'(1));
        a_i      = IW'(ocnt - CW'(2));
        p_i      = IW'(pcnt - CW'(1));
        b        = ostk[b_i];
        a        = ostk[a_i];
        top_op   = pstk[p_i];
        new_op   = 2'(value[3:0] - 4'hA);
        code_ok  = (value[3:0] >= 4'hA) && (value[3:0] <= 4'hD);
        few      = ocnt < CW'(2);
        ofull    = ocnt == CW'(DEPTH);
        pfull    = pcnt == CW'(DEPTH);
        stop     = (pcnt == '0) || (!top_op[1] && pend[1]);
        can_push = (pcnt == '0) || (!top_op[1] && new_op[1]);
        tok_opnd = (kind == 2'd0) && expect_operand;
        tok_optr = (kind == 2'd1) && code_ok && !expect_operand;
        tok_eq   = (kind == 2'd2) && !expect_operand;
        tok_bad  = !(tok_opnd || tok_optr || tok_eq);
        div_zero = 1'b0;
        res      = '0;
        unique case (top_op)
            2'd0: res = a + b;
            2'd1: res = a - b;
            2'd2: res = a * b;
            default: begin
                if (b == '0) begin
                    div_zero = 1'b1;
                end else if (b == '1) begin
                    res = -a;
                end else begin
                    res = a / b;
                end
            end
        endcase
    end

    // token acceptance, reductions and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ocnt           <= '0;
            pcnt           <= '0;
            expect_operand <= 1'b1;
            pend           <= '0;
            ready          <= 1'b1;
            done           <= 1'b0;
            answer         <= '0;
            error          <= 1'b0;
            err_code       <= '0;
        end else if (clear) begin
            state          <= S_IDLE;
            ocnt           <= '0;
            pcnt           <= '0;
            expect_operand <= 1'b1;
            pend           <= '0;
            ready          <= 1'b1;
            done           <= 1'b0;
            answer         <= '0;
            error          <= 1'b0;
            err_code       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (strobe) begin
                        unique case (1'b1)
                            tok_bad: begin
                                state    <= S_ERR;
                                ready    <= 1'b0;
                                error    <= 1'b1;
                                err_code <= E_SYN;
                            end
                            tok_opnd: begin
                                if (ofull) begin
                                    state    <= S_ERR;
                                    ready    <= 1'b0;
                                    error    <= 1'b1;
                                    err_code <= E_OVF;
                                end else begin
                                    ostk[ocnt[IW-1:0]] <= value;
                                    ocnt               <= ocnt + CW'(1);
                                    expect_operand     <= 1'b0;
                                end
                            end
                            tok_optr: begin
                                expect_operand <= 1'b1;
                                if (!can_push) begin
                                    pend  <= new_op;
                                    state <= S_REDUCE;
                                    ready <= 1'b0;
                                end else if (pfull) begin
                                    state    <= S_ERR;
                                    ready    <= 1'b0;
                                    error    <= 1'b1;
                                    err_code <= E_OVF;
                                end else begin
                                    pstk[pcnt[IW-1:0]] <= new_op;
                                    pcnt               <= pcnt + CW'(1);
                                end
                            end
                            tok_eq: begin
                                state <= S_FINAL;
                                ready <= 1'b0;
                            end
                        endcase
                    end
                end
                S_REDUCE, S_FINAL: begin
                    if (state == S_REDUCE && stop) begin
                        if (pfull) begin
                            state    <= S_ERR;
                            error    <= 1'b1;
                            err_code <= E_OVF;
                        end else begin
                            pstk[pcnt[IW-1:0]] <= pend;
                            pcnt               <= pcnt + CW'(1);
                            state              <= S_IDLE;
                            ready              <= 1'b1;
                        end
                    end else if (state == S_FINAL && pcnt == '0) begin
                        if (ocnt == CW'(1)) begin
                            answer <= b;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state    <= S_ERR;
                            error    <= 1'b1;
                            err_code <= E_SYN;
                        end
                    end else if (few) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        err_code <= E_SYN;
                    end else if (div_zero) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        err_code <= E_DIV;
                    end else begin
                        ostk[a_i] <= res;
                        ocnt      <= ocnt - CW'(1);
                        pcnt      <= pcnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_evaluator.sv
// tb_stack_evaluator: directed cases plus random expressions checked
// against a two-level (terms, then sums) precedence model.
module tb_stack_evaluator;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         strobe = 1'b0;
    logic [1:0]   kind = 2'd0;
    logic [W-1:0] value = '0;
    logic         clear = 1'b0;

    logic         ready, done, error;
    logic [W-1:0] answer;
    logic [1:0]   err_code;
    logic         ready2, done2, error2;
    logic [W-1:0] answer2;
    logic [1:0]   err_code2;

    int checks = 0;
    int errors = 0;
    int rv[5];
    int ro[4];

    stack_evaluator #(.WIDTH(W), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .kind(kind),
        .value(value), .clear(clear), .ready(ready), .done(done),
        .answer(answer), .error(error), .err_code(err_code)
    );

    stack_evaluator #(.WIDTH(W), .DEPTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .kind(kind),
        .value(value), .clear(clear), .ready(ready2), .done(done2),
        .answer(answer2), .error(error2), .err_code(err_code2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input bit junk);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            if (junk) begin
                strobe = 1'($urandom_range(0, 1));
                kind   = 2'd3;
            end
            @(negedge clk);
            n++;
        end
        strobe = 1'b0;
        if (n >= 200) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [1:0] k, input logic [W-1:0] v,
                        input bit junk);
        wait_ready(junk);
        kind   = k;
        value  = v;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        kind   = 2'd0;
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        while (!done && !error && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) chk("end_timeout", 0, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    function automatic int rnd_val();
        int r;
        case ($urandom_range(0, 5))
            0: r = int'($urandom);
            1: r = int'(32'h8000_0000);
            2: r = -1;
            default: r = int'($urandom_range(0, 20)) - 10;
        endcase
        return r;
    endfunction

    // ro: 0 +, 1 -, 2 *, 3 /; fold * and / into terms, then sum terms
    function automatic void model(input int n, output bit dz, output int r);
        longint terms[$];
        int     lows[$];
        longint cur;
        longint acc;
        dz  = 1'b0;
        cur = rv[0];
        for (int i = 0; i < n - 1; i++) begin
            longint nxt;
            nxt = rv[i + 1];
            if (ro[i] == 2) begin
                cur = longint'(int'(cur * nxt));
            end else if (ro[i] == 3) begin
                if (nxt == 0) dz = 1'b1;
                else cur = longint'(int'(cur / nxt));
            end else begin
                terms.push_back(cur);
                lows.push_back(ro[i]);
                cur = nxt;
            end
        end
        terms.push_back(cur);
        acc = terms[0];
        for (int j = 0; j < lows.size(); j++) begin
            if (lows[j] == 0) acc = longint'(int'(acc + terms[j + 1]));
            else acc = longint'(int'(acc - terms[j + 1]));
        end
        r = int'(acc);
    endfunction

    initial begin
        int cyc;
        int n;
        bit dz;
        int exp_r;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        chk("rst_answer", answer, 0);
        tick();
        reset_n = 1'b1;
        tick();

        send(0, 2, 0);
        send(1, 32'hA, 0);
        send(0, 3, 0);
        send(1, 32'hC, 0);
        chk("mul_ready", ready, 1);
        send(0, 4, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("prec_lat", cyc, 3);
        chk("prec_done", done, 1);
        chk("prec_ans", answer, 14);

        do_clear();
        send(0, 8, 0);
        send(1, 32'hB, 0);
        send(0, 3, 0);
        send(1, 32'hB, 0);
        chk("red_busy0", ready, 0);
        tick();
        chk("red_busy1", ready, 0);
        tick();
        chk("red_back", ready, 1);
        send(0, 2, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("left_assoc", answer, 3);

        do_clear();
        send(0, $unsigned(-7), 0);
        send(1, 32'hD, 0);
        send(0, 2, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("div_trunc", answer, $unsigned(-3));

        do_clear();
        send(0, 7, 0);
        send(1, 32'hD, 0);
        send(0, 0, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("dz_error", error, 1);
        chk("dz_code", err_code, 3);
        do_clear();
        chk("clr_ready", ready, 1);
        chk("clr_code", err_code, 0);
        send(0, 5, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("single_lat", cyc, 1);
        chk("single_ans", answer, 5);
        strobe = 1'b1;
        kind   = 2'd0;
        value  = 1;
        tick();
        strobe = 1'b0;
        tick();
        chk("hold_done", done, 1);
        chk("hold_ans", answer, 5);

        do_clear();
        send(0, 4, 0);
        chk("syn_ok", error, 0);
        send(0, 5, 0);
        chk("syn_2opnd", err_code, 1);
        do_clear();
        send(1, 32'hA, 0);
        chk("syn_first_op", err_code, 1);
        do_clear();
        send(0, 6, 0);
        send(1, 32'hA, 0);
        send(2, 0, 0);
        chk("syn_eq", err_code, 1);
        do_clear();
        send(0, 6, 0);
        send(1, 32'h7, 0);
        chk("syn_badop", err_code, 1);
        do_clear();
        send(3, 0, 0);
        chk("syn_kind3", err_code, 1);

        do_clear();
        send(0, 1, 0);
        send(1, 32'hA, 0);
        send(0, 2, 0);
        send(1, 32'hC, 0);
        chk("ovf_pre", error2, 0);
        send(0, 3, 0);
        chk("ovf_err", error2, 1);
        chk("ovf_code", err_code2, 2);
        chk("ovf_wide", error, 0);

        do_clear();
        clear  = 1'b1;
        strobe = 1'b1;
        kind   = 2'd0;
        value  = 5;
        tick();
        clear  = 1'b0;
        strobe = 1'b0;
        send(0, 6, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("clr_wins", answer, 6);

        do_clear();
        send(0, 1, 0);
        send(1, 32'hC, 0);
        send(0, 2, 0);
        send(1, 32'hA, 0);
        send(0, 3, 0);
        send(2, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_ready", ready, 1);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        chk("mid_code", err_code, 0);
        chk("mid_answer", answer, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send(0, 9, 0);
        send(2, 0, 0);
        wait_end(cyc);
        chk("post_rst", answer, 9);

        for (int t = 0; t < 40; t++) begin
            do_clear();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) rv[i] = rnd_val();
            for (int i = 0; i < n - 1; i++) ro[i] = $urandom_range(0, 3);
            model(n, dz, exp_r);
            for (int i = 0; i < n; i++) begin
                send(0, $unsigned(rv[i]), 1);
                if (i < n - 1) send(1, 32'hA + 32'(ro[i]), 1);
            end
            send(2, 0, 1);
            wait_end(cyc);
            if (dz) begin
                chk("rnd_dz_err", error, 1);
                chk("rnd_dz_code", err_code, 3);
            end else begin
                chk("rnd_done", done, 1);
                chk("rnd_ans", answer, $unsigned(exp_r));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
